// File: rtl/rssb_pkg.sv
// rssb_pkg: shared types and constants for the RSSB multi-cycle core.
// The state enum, the halt-word generator and the retired-counter width live
// here so the core and any checker agree on them.
package rssb_pkg;

    // Core FSM states: an instruction walks FETCH -> DECODE -> EXEC.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } rssb_state_e;

    // Width of the retired-instruction counter (saturating).
    localparam int RETIRED_W = 16;

    // Widest data word the halt-word helper supports.
    localparam int HALT_MAX_W = 64;

    // All-ones word of the given width, zero-extended to HALT_MAX_W bits.
    // Callers truncate the result to their own data width.
    function automatic logic [HALT_MAX_W-1:0] halt_word(input int unsigned width);
        return ~({HALT_MAX_W{1'b1}} << width);
    endfunction

endpackage

// File: rtl/rssb_mem.sv
// rssb_mem: single-port RAM, WIDTH x DEPTH, synchronous read with one cycle
// of latency and one write port. Contents are not reset.
module rssb_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write on strobe; always register the word at the current address.
    // The core never needs a read and a write in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/rssb_multicycle.sv
// rssb_multicycle: parametrised multi-cycle RSSB (reverse-subtract,
// skip-if-borrow) core with on-chip memory, host load port, start/done
// handshake, halt detection and a saturating retired-instruction counter.
//
// Handshake: start is accepted on a rising edge only while busy=0; busy is
// high from that edge until the edge on which the halt word is decoded, and
// done is high for exactly the following cycle. load_en writes only while idle.
//
// Build option RSSB_OUT_EN: when defined, address DEPTH-1 acts as an output
// port for EXEC writes (out_valid/out_data); when undefined it is plain memory
// and out_valid/out_data stay 0.
module rssb_multicycle
    import rssb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int START_ADDR = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 load_en,
    input  logic [AW-1:0]        load_addr,
    input  logic [WIDTH-1:0]     load_data,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        pc_out,
    output logic [WIDTH-1:0]     acc_out,
    output logic [RETIRED_W-1:0] retired,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           dbg_state
);

    localparam logic [WIDTH-1:0] HALT = WIDTH'(halt_word(WIDTH));

    rssb_state_e          r_state;
    logic [AW-1:0]        r_pc;
    logic [AW-1:0]        r_op1;
    logic [WIDTH-1:0]     r_acc;
    logic [RETIRED_W-1:0] r_retired;
    logic                 r_done;

    logic                 w_mem_we;
    logic [AW-1:0]        w_mem_addr;
    logic [WIDTH-1:0]     w_mem_wdata;
    logic [WIDTH-1:0]     w_rdata;
    logic [WIDTH-1:0]     w_r;
    logic [AW-1:0]        w_pc_next;
    logic                 w_exec_we;

    rssb_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_rdata)
    );

    // Reverse subtract: memory operand minus accumulator, wrapping.
    assign w_r = w_rdata - r_acc;

    // A negative result skips the next instruction; PC wraps modulo DEPTH.
    assign w_pc_next = w_r[WIDTH-1] ? (r_pc + AW'(2)) : (r_pc + AW'(1));

`ifdef RSSB_OUT_EN
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    // Results aimed at the top address go to the output port, not memory.
    assign w_exec_we = (r_op1 != AW'(DEPTH - 1));

    // Output port strobe: one cycle after an EXEC that targets the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == ST_EXEC && !w_exec_we) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_r;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
`else
    assign w_exec_we = 1'b1;
    assign out_valid = 1'b0;
    assign out_data  = '0;
`endif

    // Memory port mux: host loads while idle, core fetch/operand/writeback otherwise.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = load_addr;
        w_mem_wdata = load_data;
        case (r_state)
            ST_IDLE:   w_mem_we = load_en;
            ST_FETCH:  w_mem_addr = r_pc;
            ST_DECODE: w_mem_addr = w_rdata[AW-1:0];
            ST_EXEC: begin
                w_mem_addr  = r_op1;
                w_mem_wdata = w_r;
                w_mem_we    = w_exec_we;
            end
            default: ;
        endcase
    end

    // Core FSM and architectural state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_op1     <= '0;
            r_acc     <= '0;
            r_retired <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_FETCH;
                        r_pc      <= AW'(START_ADDR);
                        r_acc     <= '0;
                        r_retired <= '0;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_rdata == HALT) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_op1   <= w_rdata[AW-1:0];
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_acc <= w_r;
                    r_pc  <= w_pc_next;
                    if (r_retired != {RETIRED_W{1'b1}}) begin
                        r_retired <= r_retired + 1'b1;
                    end
                    r_state <= ST_FETCH;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign pc_out    = r_pc;
    assign acc_out   = r_acc;
    assign retired   = r_retired;
    assign dbg_state = r_state;

endmodule

// File: doc/rssb_multicycle.md
# rssb_multicycle

Parametrised multi-cycle RSSB (reverse-subtract, skip-if-borrow) processor core with an on-chip word-addressed memory. It generalises the fixed 8-bit RSSB datapath to any data width and memory depth, and adds a program-load port, a start/done handshake, halt detection and a retired-instruction counter. It is the execution core of the RSSB subsystem, driven by a host that loads a program and starts it.

## Interface
- WIDTH, 8, data word width in bits; must be at least $clog2(DEPTH)
- DEPTH, 16, memory words; must be a power of two; AW = $clog2(DEPTH)
- START_ADDR, 0, PC value loaded on an accepted start
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  start request; accepted only when busy=0
- load_en  input  1  host memory write strobe; ignored when busy=1
- load_addr  input  AW  host write address
- load_data  input  WIDTH  host write data
- busy  output  1  core is executing
- done  output  1  one-cycle pulse when the core halts
- pc_out  output  AW  current PC
- acc_out  output  WIDTH  accumulator
- retired  output  16  count of completed instructions; saturates at 16'hFFFF
- out_valid  output  1  output-port strobe (see Configuration)
- out_data  output  WIDTH  output-port data

## Operation
- States: IDLE, FETCH, DECODE, EXEC.
- Reset: state=IDLE; busy, done, out_valid, pc_out, acc_out, retired and out_data are all 0. Memory contents are not reset.
- IDLE:
  - A load_en write commits at the edge.
  - start → FETCH, with pc=START_ADDR, acc=0 and retired=0.
  - start and load_en in the same cycle: both take effect, and the first fetch sees the loaded word.
- FETCH: issue a synchronous read at pc → DECODE.
- DECODE: the read data is the instruction word.
  - All-ones word: halt. Go to IDLE, pulse done, leave pc, acc and retired unchanged.
  - Otherwise: op1 = word[AW-1:0], issue a read at op1 → EXEC.
- EXEC, with M = read data:
  - r = M − acc, modulo 2^WIDTH.
  - acc ← r; mem[op1] ← r; retired += 1.
  - If r[WIDTH-1]=1 (negative), pc ← pc+2; otherwise pc ← pc+1. PC arithmetic is modulo DEPTH (wraps).
  - Then → FETCH.
- busy=1 in FETCH, DECODE and EXEC.
- start while busy is ignored. load_en while busy is ignored and does not write.
- Self-modifying code is legal: an EXEC write is visible to the next FETCH.

## Timing
- Each instruction takes 3 cycles (FETCH, DECODE, EXEC); single-port RAM with 1-cycle read latency.
- busy rises on the edge that accepts start.
- done is high for exactly the cycle after the DECODE that sees the halt word; busy is 0 in that same cycle.
- A halt word at START_ADDR gives done 2 cycles after start is accepted.
- rst asserted at any time forces every output to its reset value immediately. An in-flight EXEC write is lost only if rst is asserted before its edge.

## Configuration
- RSSB_OUT_EN defined: address DEPTH-1 becomes an output port.
  - An EXEC with op1=DEPTH-1 does not write memory. It pulses out_valid for one cycle with out_data=r.
  - acc, pc and retired update normally.
  - Reads of DEPTH-1 return the memory word.
- RSSB_OUT_EN undefined: address DEPTH-1 is ordinary memory; out_valid and out_data are tied to 0.

## Structure
- rssb_pkg holds:
  - the state enum type;
  - the HALT_WORD constant/function, all-ones of WIDTH;
  - the retired counter width constant, 16.
- Sub-module rssb_mem: a single-port synchronous-read RAM, WIDTH×DEPTH, with one write port. The core muxes the host load port and the EXEC write onto it.

## Test plan
(WIDTH=8, DEPTH=16 unless noted.)
- Reset with rst=1, then release → busy=0, done=0, pc_out=0, acc_out=0, retired=0, out_valid=0.
- Load mem[0]=5, mem[5]=3, mem[1]=8'hFF; start → mem[5]=3, acc_out=3, pc_out=1; done pulses with retired=1.
- Load mem[0]=5, mem[5]=3, mem[1]=6, mem[6]=1, mem[3]=8'hFF; start → second result is 8'hFE (negative), so the skip goes to pc=3; halt with acc_out=8'hFE, mem[6]=8'hFE, retired=2.
- START_ADDR=15; mem[15]=4, mem[4]=8'h80; start → r=8'h80 is negative, so pc wraps 15+2 → 1.
- Reset mid-program: rst asserted during EXEC → busy=0 immediately and pc_out=0; memory written before the reset is retained; restart runs correctly. Also: start and load_en asserted while busy → no effect.
- With RSSB_OUT_EN: mem[0]=15, mem[15]=9, mem[1]=8'hFF → out_valid pulses once with out_data=9; mem[15] is still 9; acc_out=9.
